// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: clock inhibit, request-to-send, device-clocked
// frame shifting (LSB first, odd parity, stop), ACK check and return to idle.
module ps2_host_tx #(
  parameter int CLK_FREQ_HZ    = 100_000_000,
  parameter int INHIBIT_CYCLES = CLK_FREQ_HZ / 10_000,
  parameter int TIMEOUT_CYCLES = CLK_FREQ_HZ / 50,
  parameter int FILTER_LEN     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       rx_inhibit,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic [2:0] o_dbg_state
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_RTS       = 3'd2,
    S_DATA      = 3'd3,
    S_PARITY    = 3'd4,
    S_STOP      = 3'd5,
    S_WAIT_IDLE = 3'd6
  } state_t;

  // Handshake: a request is taken on a cycle where tx_valid and tx_ready are both
  // high; tx_ready stays low from then until the cycle after the done/error pulse.

  // Index 0 = PS2_CLK, index 1 = PS2_DATA.
  logic [1:0]                 r_sync1;
  logic [1:0]                 r_sync2;
  logic [1:0][FILTER_LEN-1:0] r_hist;
  logic [1:0]                 r_filt;
  logic                       r_clk_prev;
  logic                       w_clk_fall;
  logic                       w_clk_filt;
  logic                       w_data_filt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1    <= '1;
      r_sync2    <= '1;
      r_hist     <= '1;
      r_filt     <= '1;
      r_clk_prev <= 1'b1;
    end else begin
      r_sync1    <= {ps2_data_i, ps2_clk_i};
      r_sync2    <= r_sync1;
      r_clk_prev <= r_filt[0];
      for (int i = 0; i < 2; i++) begin
        r_hist[i] <= {r_hist[i][FILTER_LEN-2:0], r_sync2[i]};
        // Level only changes once the whole history window agrees.
        if (&r_hist[i]) begin
          r_filt[i] <= 1'b1;
        end else if (!(|r_hist[i])) begin
          r_filt[i] <= 1'b0;
        end
      end
    end
  end

  assign w_clk_filt  = r_filt[0];
  assign w_data_filt = r_filt[1];
  assign w_clk_fall  = r_clk_prev & ~r_filt[0];

  state_t        r_state;
  state_t        w_state_nxt;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_nxt;
  logic          r_parity;
  logic          w_parity_nxt;
  logic [3:0]    r_bit_cnt;
  logic [3:0]    w_bit_cnt_nxt;
  logic [IW-1:0] r_inh_cnt;
  logic [IW-1:0] w_inh_cnt_nxt;
  logic [TW-1:0] r_to_cnt;
  logic [TW-1:0] w_to_cnt_nxt;
  logic [TW-1:0] w_to_inc;
  logic          w_active;
  logic          w_fail;

  logic r_tx_ready;
  logic r_tx_done;
  logic r_tx_error;
  logic r_rx_inhibit;
  logic r_clk_oe;
  logic r_data_oe;
  logic w_ready_nxt;
  logic w_done_nxt;
  logic w_error_nxt;
  logic w_inhibit_nxt;
  logic w_clk_oe_nxt;
  logic w_data_oe_nxt;

  assign w_to_inc = r_to_cnt + 1'b1;
  assign w_active = (r_state != S_IDLE) && (r_state != S_INHIBIT);

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_parity_nxt  = r_parity;
    w_bit_cnt_nxt = r_bit_cnt;
    w_inh_cnt_nxt = r_inh_cnt;
    w_to_cnt_nxt  = r_to_cnt;
    w_data_oe_nxt = r_data_oe;
    w_done_nxt    = 1'b0;
    w_error_nxt   = 1'b0;
    w_fail        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (tx_valid && r_tx_ready) begin
          w_state_nxt   = S_INHIBIT;
          w_shift_nxt   = tx_data;
          w_parity_nxt  = ~^tx_data;
          w_bit_cnt_nxt = '0;
          w_inh_cnt_nxt = '0;
        end
      end
      S_INHIBIT: begin
        if (r_inh_cnt == INH_LAST) begin
          w_state_nxt   = S_RTS;
          w_data_oe_nxt = 1'b1;
          w_to_cnt_nxt  = '0;
        end else begin
          w_inh_cnt_nxt = r_inh_cnt + 1'b1;
        end
      end
      S_RTS: begin
        w_to_cnt_nxt = w_to_inc;
        if (w_clk_fall) begin
          w_state_nxt   = S_DATA;
          w_data_oe_nxt = ~r_shift[0];
          w_shift_nxt   = r_shift >> 1;
          w_bit_cnt_nxt = 4'd1;
        end
      end
      S_DATA: begin
        w_to_cnt_nxt = w_to_inc;
        if (w_clk_fall) begin
          if (r_bit_cnt == 4'd8) begin
            w_state_nxt   = S_PARITY;
            w_data_oe_nxt = ~r_parity;
          end else begin
            w_data_oe_nxt = ~r_shift[0];
            w_shift_nxt   = r_shift >> 1;
            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          end
        end
      end
      S_PARITY: begin
        w_to_cnt_nxt = w_to_inc;
        if (w_clk_fall) begin
          w_state_nxt   = S_STOP;
          w_data_oe_nxt = 1'b0;
        end
      end
      S_STOP: begin
        w_to_cnt_nxt = w_to_inc;
        if (w_clk_fall) begin
          if (!w_data_filt) begin
            w_state_nxt = S_WAIT_IDLE;
          end else begin
            w_fail = 1'b1;
          end
        end
      end
      S_WAIT_IDLE: begin
        w_to_cnt_nxt = w_to_inc;
        if (w_clk_filt && w_data_filt) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_active && (w_to_inc == TO_LIMIT)) begin
      w_fail = 1'b1;
    end
    if (w_fail) begin
      w_state_nxt = S_IDLE;
      w_done_nxt  = 1'b0;
      w_error_nxt = 1'b1;
    end
    if (w_state_nxt == S_IDLE) begin
      w_data_oe_nxt = 1'b0;
    end

    // Ready is held off for the pulse cycle so it rises on the following edge.
    w_clk_oe_nxt  = (w_state_nxt == S_INHIBIT);
    w_inhibit_nxt = (w_state_nxt != S_IDLE);
    w_ready_nxt   = (w_state_nxt == S_IDLE) && !w_done_nxt && !w_error_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_parity     <= 1'b0;
      r_bit_cnt    <= '0;
      r_inh_cnt    <= '0;
      r_to_cnt     <= '0;
      r_tx_ready   <= 1'b0;
      r_tx_done    <= 1'b0;
      r_tx_error   <= 1'b0;
      r_rx_inhibit <= 1'b0;
      r_clk_oe     <= 1'b0;
      r_data_oe    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shift      <= w_shift_nxt;
      r_parity     <= w_parity_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_inh_cnt    <= w_inh_cnt_nxt;
      r_to_cnt     <= w_to_cnt_nxt;
      r_tx_ready   <= w_ready_nxt;
      r_tx_done    <= w_done_nxt;
      r_tx_error   <= w_error_nxt;
      r_rx_inhibit <= w_inhibit_nxt;
      r_clk_oe     <= w_clk_oe_nxt;
      r_data_oe    <= w_data_oe_nxt;
    end
  end

  assign tx_ready    = r_tx_ready;
  assign tx_done     = r_tx_done;
  assign tx_error    = r_tx_error;
  assign rx_inhibit  = r_rx_inhibit;
  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a PS/2 device model that clocks
// frames at 12.5 kHz, checked against a frame model built from the byte.
module tb_ps2_host_tx;

  localparam int CLK_HZ = 1_000_000;
  localparam int INH    = CLK_HZ / 10_000;
  localparam int TMO    = CLK_HZ / 50;
  localparam int HALF   = CLK_HZ / 25_000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] tx_data      = 8'h00;
  logic       tx_valid     = 1'b0;
  logic       dev_clk_low  = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       tx_ready, tx_done, tx_error, rx_inhibit;
  logic       ps2_clk_oe, ps2_data_oe;
  logic [2:0] dbg_state;
  logic       ps2_clk_line, ps2_data_line;

  assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(.CLK_FREQ_HZ(CLK_HZ)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .rx_inhibit (rx_inhibit),
    .ps2_clk_i  (ps2_clk_line),
    .ps2_data_i (ps2_data_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .o_dbg_state(dbg_state)
  );

  // ---------------- monitor ----------------
  int         cyc = 0;
  int         done_cnt = 0, err_cnt = 0, both_cnt = 0;
  int         err_cyc = 0, release_cyc = 0, hi_run = 0, last_inh_len = 0;
  logic       pulse_prev = 1'b0, ready_after = 1'b0, level_after = 1'b0, clk_oe_prev = 1'b0;
  logic [1:0] pulse_oe = 2'b00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    pulse_prev  <= tx_done | tx_error;
    clk_oe_prev <= ps2_clk_oe;
    if (pulse_prev) begin
      ready_after <= tx_ready;
      level_after <= tx_done | tx_error;
    end
    if (tx_done) begin
      done_cnt <= done_cnt + 1;
      pulse_oe <= {ps2_clk_oe, ps2_data_oe};
    end
    if (tx_error) begin
      err_cnt  <= err_cnt + 1;
      err_cyc  <= cyc;
      pulse_oe <= {ps2_clk_oe, ps2_data_oe};
    end
    if (tx_done && tx_error) both_cnt <= both_cnt + 1;
    if (clk_oe_prev && !ps2_clk_oe) release_cyc <= cyc;
    if (ps2_clk_oe) begin
      hi_run <= hi_run + 1;
    end else if (hi_run != 0) begin
      last_inh_len <= hi_run;
      hi_run       <= 0;
    end
  end

  initial begin
    repeat (90_000) @(posedge clk);
    $display("FAIL watchdog: observed no end of test, required finish within 90000 cycles");
    $fatal(1);
  end

  // ---------------- scoreboard / checks ----------------
  int   vectors = 0;
  int   miscompares = 0;
  logic track_inh = 1'b0;
  logic inh_ok = 1'b1;
  int   base_done = 0, base_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] expected_frame(input logic [7:0] d);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    f[9]  = ($countones(d) % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (track_inh && !rx_inhibit && !tx_done && !tx_error &&
          done_cnt == base_done && err_cnt == base_err) inh_ok = 1'b0;
    end
  endtask

  task automatic request(input logic [7:0] d);
    base_done = done_cnt;
    base_err  = err_cnt;
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
  endtask

  task automatic wait_release();
    int n = 0;
    while (ps2_clk_oe && n < INH + 10) begin
      tick(1);
      n++;
    end
  endtask

  task automatic wait_pulse(input int limit);
    int n = 0;
    while (done_cnt == base_done && err_cnt == base_err && n < limit) begin
      tick(1);
      n++;
    end
    tick(2);
  endtask

  // Device: samples the data line just before each falling clock edge it drives.
  task automatic dev_frame(input int nclk, input bit ack_low, input bit glitch,
                           input bit poke, output logic [10:0] seen);
    seen = '0;
    tick(HALF);
    for (int k = 0; k < nclk; k++) begin
      seen[k] = ps2_data_line;
      if (k == 10 && ack_low) begin
        dev_data_low = 1'b1;
        tick(10);
      end
      if (poke && k == 6) begin
        tx_data  = 8'($urandom);
        tx_valid = 1'b1;
      end
      dev_clk_low = 1'b1;
      tick(HALF);
      dev_clk_low = 1'b0;
      if (poke && k == 6) tx_valid = 1'b0;
      if (glitch && k == 3) begin
        tick(10);
        dev_clk_low = 1'b1;
        tick(2);
        dev_clk_low = 1'b0;
        tick(HALF - 12);
      end else begin
        tick(HALF);
      end
    end
    dev_data_low = 1'b0;
  endtask

  task automatic run_transfer(input logic [7:0] d, input bit ack_low, input bit glitch,
                              input bit poke, input string tag);
    logic [10:0] seen;
    inh_ok = 1'b1;
    request(d);
    check({tag, "/accept"}, {28'd0, tx_ready, rx_inhibit, ps2_clk_oe, ps2_data_oe}, 32'b0110);
    track_inh = 1'b1;
    wait_release();
    check({tag, "/rts_oe"}, {30'd0, ps2_clk_oe, ps2_data_oe}, 32'b01);
    tick(1);
    check({tag, "/inhibit_len"}, last_inh_len, INH);
    dev_frame(11, ack_low, glitch, poke, seen);
    check({tag, "/frame"}, {21'd0, seen}, {21'd0, expected_frame(d)});
    wait_pulse(300);
    track_inh = 1'b0;
    check({tag, "/done_pulses"}, done_cnt - base_done, ack_low ? 1 : 0);
    check({tag, "/error_pulses"}, err_cnt - base_err, ack_low ? 0 : 1);
    check({tag, "/after_pulse"}, {28'd0, pulse_oe, ready_after, level_after}, 32'b0010);
    check({tag, "/rx_inhibit_held"}, {31'd0, inh_ok}, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [10:0] partial;
    logic [7:0]  d;

    tick(3);
    check("reset_outputs", {26'd0, tx_ready, tx_done, tx_error, rx_inhibit, ps2_clk_oe, ps2_data_oe}, 0);
    rst = 1'b1;
    tick(1);
    check("ready_after_reset", {31'd0, tx_ready}, 1);

    run_transfer(8'hED, 1'b1, 1'b0, 1'b0, "set_leds_ed");
    run_transfer(8'h07, 1'b1, 1'b0, 1'b0, "parity_07");
    run_transfer(8'h00, 1'b1, 1'b0, 1'b0, "parity_00");
    run_transfer(8'($urandom), 1'b0, 1'b0, 1'b0, "ack_high");
    for (int i = 0; i < 3; i++) run_transfer(8'($urandom), 1'b1, 1'b0, 1'b0, "random");
    run_transfer(8'($urandom), 1'b1, 1'b1, 1'b1, "glitch_busy");
    tick(20);
    check("no_queued_request", {29'd0, ps2_clk_oe, tx_ready, rx_inhibit}, 32'b010);

    // Device never clocks after request-to-send.
    request(8'($urandom));
    wait_pulse(TMO + INH + 100);
    check("timeout_error", err_cnt - base_err, 1);
    check("timeout_done", done_cnt - base_done, 0);
    check("timeout_latency", err_cyc - release_cyc, TMO);
    check("timeout_release", {29'd0, pulse_oe, ready_after}, 32'b001);

    // Reset while bit 4 is on the wire; bit 4 forced to 0 so data is being pulled low.
    d = 8'($urandom) & 8'hEF;
    request(d);
    wait_release();
    dev_frame(5, 1'b0, 1'b0, 1'b0, partial);
    check("mid_frame_lines", {29'd0, ps2_clk_oe, ps2_data_oe, rx_inhibit}, 32'b011);
    rst = 1'b0;
    tick(1);
    check("reset_mid_outputs", {26'd0, ps2_clk_oe, ps2_data_oe, tx_done, tx_error, tx_ready, rx_inhibit}, 0);
    rst = 1'b1;
    tick(1);
    check("reset_mid_ready", {31'd0, tx_ready}, 1);
    tick(20);
    check("reset_mid_no_pulse", (done_cnt - base_done) + (err_cnt - base_err), 0);
    run_transfer(8'hFF, 1'b1, 1'b0, 1'b0, "reset_ff");

    check("pulse_exclusive", both_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter that sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard over the same PS2_CLK/PS2_DATA pair the keyboard decoder receives on. It runs the full host-request sequence: clock inhibit, request-to-send, device-clocked bit shifting, odd parity, stop bit and device ACK. It drives open-drain enables only; top level maps them as `line = oe ? 0 : z`. While it is active it raises `rx_inhibit` so the receive path discards its own echoes.

## Interface

- CLK_FREQ_HZ, 100_000_000, system clock frequency.
- INHIBIT_CYCLES, CLK_FREQ_HZ/10_000 (100 µs), duration PS2_CLK is held low before request-to-send.
- TIMEOUT_CYCLES, CLK_FREQ_HZ/50 (20 ms), maximum time from clock release to ACK completion.
- FILTER_LEN, 4, consecutive identical synchronized samples required to accept a PS/2 line level.

- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset: **one clock; reset is synchronous and active-low**.
- tx_data  in  8  command byte, sampled on accept.
- tx_valid  in  1  request to send tx_data.
- tx_ready  out  1  block idle, accepts a request.
- tx_done  out  1  one-cycle pulse: byte ACKed, bus idle.
- tx_error  out  1  one-cycle pulse: no ACK, or timeout.
- rx_inhibit  out  1  high from accept until done/error.
- ps2_clk_i  in  1  PS2_CLK pad level (asynchronous).
- ps2_data_i  in  1  PS2_DATA pad level (asynchronous).
- ps2_clk_oe  out  1  1 = pull PS2_CLK low.
- ps2_data_oe  out  1  1 = pull PS2_DATA low.

## Operation

- Input conditioning: each pad goes through a 2-flop synchronizer and then a FILTER_LEN-sample level filter. A filtered falling edge (`clk_fall`) is a one-cycle strobe.
- Accept: in IDLE, when `tx_valid && tx_ready`:
  - latch tx_data;
  - compute parity = ~^tx_data (odd parity);
  - bit counter = 0;
  - go to INHIBIT.
- States:
  - IDLE: both oe = 0; tx_ready = 1.
  - INHIBIT: ps2_clk_oe = 1 for exactly INHIBIT_CYCLES cycles, then go to RTS.
  - RTS: ps2_clk_oe = 0 and ps2_data_oe = 1 (start bit 0) in the same cycle; timeout counter starts. Each clk_fall advances the frame:
    - clk_fall 1..8: ps2_data_oe = ~data[n], n = 0..7, LSB first (DATA state).
    - clk_fall 9: ps2_data_oe = ~parity (PARITY).
    - clk_fall 10: ps2_data_oe = 0, i.e. stop bit 1 (STOP).
    - clk_fall 11: sample filtered data (ACK). Low: go to WAIT_IDLE. High: error.
  - WAIT_IDLE: wait until filtered clk and data are both high, then pulse tx_done and go to IDLE.
- Error path: release both oe, pulse tx_error and return to IDLE. Triggers:
  - ACK sampled high;
  - timeout counter reaches TIMEOUT_CYCLES in any state from RTS through WAIT_IDLE.
- tx_valid while not ready is ignored; there is no queuing.
- tx_data changes after accept have no effect on the frame in progress.
- rx_inhibit = 1 in every state except IDLE.

## Timing

- Reset (rst = 0 at a clk edge) forces:
  - state IDLE;
  - all outputs 0 (tx_ready, tx_done, tx_error, rx_inhibit, ps2_clk_oe, ps2_data_oe);
  - synchronizers and filters to 1.
- tx_ready rises on the first clk edge with rst = 1.
- Reset mid-transfer releases both lines on that edge, with no done/error pulse.
- Accept cycle T: tx_ready = 0, rx_inhibit = 1 and ps2_clk_oe = 1 are all registered at T+1.
- ps2_clk_oe stays high for INHIBIT_CYCLES cycles. ps2_clk_oe falls and ps2_data_oe rises on the same edge.
- Pad-to-strobe latency: 2 synchronizer cycles + FILTER_LEN cycles. ps2_data_oe updates on the edge after clk_fall, well inside the device's low clock phase (≥30 µs).
- tx_done and tx_error are each exactly 1 cycle wide and mutually exclusive. tx_ready returns to 1 on the cycle after the pulse.
- A PS2_CLK glitch shorter than FILTER_LEN cycles produces no clk_fall.
- All counters are unsigned and sized by $clog2 of their parameter; none wrap during legal operation.

## Test plan

- Send 0xED with a device model clocking at 12.5 kHz:
  - data-line bits seen at device rising edges: 0 (start), 1,0,1,1,0,1,1,1, parity 1, stop 1;
  - model ACKs low at the 11th clock;
  - tx_done pulses once after the lines idle; rx_inhibit is high throughout.
- Inhibit duration at defaults: ps2_clk_oe high for exactly 10_000 cycles. Data bit for 0x07 parity = 0; for 0x00 parity = 1.
- Model completes 11 clocks but holds data high at ACK: tx_error pulses, both oe = 0, tx_ready = 1 next cycle.
- Model never clocks after RTS: tx_error pulses TIMEOUT_CYCLES cycles after clock release; lines released.
- rst driven low during bit 4 of DATA: both oe = 0 on that edge, no pulses. After release, a new 0xFF transfer completes correctly.
- A 2-cycle low glitch on PS2_CLK during DATA causes no bit advance, and the frame still completes with tx_done. A tx_valid pulse while busy is ignored.
